btb_branch_predictor: RTL and testbench

- Parametrised direct-mapped branch target buffer with per-entry saturating direction counters.
- Sits beside the PC in fetch and supplies a predicted next fetch address, replacing the fixed pc+4 default.
- Trained from the branch-resolve stage (MEM in the 5-stage pipeline) with the actual outcome and target.
- Keeps a saturating misprediction statistic for the CPU tracker.

---
 rtl/btb_branch_predictor.sv | 165 ++++++++++++++++
 tb/tb_btb_branch_predictor.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_branch_predictor.sv
// -----------------------------------------------------------------------------
// btb_branch_predictor
//
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Fetch looks up pc_F combinationally and gets a predicted next PC
// (the stored target when the entry predicts taken, otherwise pc_F+4). The
// resolve stage trains the table with the actual outcome and target, and every
// mispredicted update bumps a saturating statistic counter.
//
// Ports:
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   pc_F               fetch PC to look up
//   hit_F              valid entry matches pc_F
//   pred_taken_F       prediction is taken
//   pred_next_F        predicted next fetch PC
//   upd_valid          one strobe per resolved branch/jump
//   upd_pc             PC of the resolved instruction
//   upd_taken          actual outcome (jumps report taken)
//   upd_target         actual taken target
//   upd_pred_taken     direction that was predicted at fetch
//   upd_pred_next      next PC that was predicted at fetch
//   invalidate         clear all valid bits (wins over a same-cycle update)
//   mispredict         combinational: current update was mispredicted
//   stat_mispredict    saturating misprediction count
// -----------------------------------------------------------------------------
module btb_branch_predictor #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int STAT_W   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [31:0]       pc_F,
  output logic              hit_F,
  output logic              pred_taken_F,
  output logic [31:0]       pred_next_F,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_next,
  input  logic              invalidate,
  output logic              mispredict,
  output logic [STAT_W-1:0] stat_mispredict
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  // Weakly taken: MSB set, all lower bits clear (also correct for CTR_BITS = 1).
  localparam logic [CTR_BITS-1:0] CTR_WT   = ~(CTR_MAX >> 1);
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
  localparam logic [STAT_W-1:0]   STAT_MAX = '1;
  localparam logic [STAT_W-1:0]   STAT_ONE = STAT_W'(1);

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [TAG_W-1:0]    tag_d    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [31:0]         target_d [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d    [ENTRIES];
  logic [STAT_W-1:0]   stat_q, stat_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;
  logic             unused_pc_lsbs;

  assign lk_idx = pc_F[IDX_W+1:2];
  assign lk_tag = pc_F[31:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Instructions are word aligned; the byte offset never selects anything.
  assign unused_pc_lsbs = ^{pc_F[1:0], upd_pc[1:0]};

  // Zero-latency lookup from the registered table (read-before-write).
  always_comb begin
    hit_F        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_F = hit_F && ctr_q[lk_idx][CTR_BITS-1];
    if (pred_taken_F) begin
      pred_next_F = target_q[lk_idx];
    end else begin
      pred_next_F = pc_F + 32'd4;
    end
  end

  // Not-taken outcomes are judged on direction only; taken ones also on target.
  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_pred_next != upd_target)));

  assign stat_mispredict = stat_q;

  // Table training and invalidate; invalidate discards a concurrent update.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (invalidate) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          target_d[up_idx] = upd_target;
          if (ctr_q[up_idx] != CTR_MAX) begin
            ctr_d[up_idx] = ctr_q[up_idx] + CTR_ONE;
          end else begin
            ctr_d[up_idx] = ctr_q[up_idx];
          end
        end else begin
          if (ctr_q[up_idx] != '0) begin
            ctr_d[up_idx] = ctr_q[up_idx] - CTR_ONE;
          end else begin
            ctr_d[up_idx] = ctr_q[up_idx];
          end
        end
      end else if (upd_taken) begin
        // Allocate, evicting whatever aliased into this slot.
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = upd_target;
        ctr_d[up_idx]    = CTR_WT;
      end else begin
        valid_d = valid_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Saturating misprediction statistic; counted even during invalidate.
  always_comb begin
    if (mispredict && (stat_q != STAT_MAX)) begin
      stat_d = stat_q + STAT_ONE;
    end else begin
      stat_d = stat_q;
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      stat_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
      stat_q   <= stat_d;
    end
  end

endmodule

// File: tb/tb_btb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_btb_branch_predictor
//
// Directed bench for btb_branch_predictor (ENTRIES = 16, CTR_BITS = 2,
// STAT_W = 4). Expected values are pushed to a scoreboard queue as each step
// is driven and popped/compared once the outputs have settled.
// -----------------------------------------------------------------------------
module tb_btb_branch_predictor;

  logic        CLK;
  logic        nRST;
  logic [31:0] pc_F;
  logic        hit_F;
  logic        pred_taken_F;
  logic [31:0] pred_next_F;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_next;
  logic        invalidate;
  logic        mispredict;
  logic [3:0]  stat_mispredict;

  int checks = 0;
  int errors = 0;

  localparam int S_HIT  = 0;
  localparam int S_PT   = 1;
  localparam int S_NEXT = 2;
  localparam int S_MP   = 3;
  localparam int S_STAT = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  btb_branch_predictor #(
    .ENTRIES  (16),
    .CTR_BITS (2),
    .STAT_W   (4)
  ) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .pc_F            (pc_F),
    .hit_F           (hit_F),
    .pred_taken_F    (pred_taken_F),
    .pred_next_F     (pred_next_F),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_next   (upd_pred_next),
    .invalidate      (invalidate),
    .mispredict      (mispredict),
    .stat_mispredict (stat_mispredict)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic expect_v(input string name, input int sel, input logic [31:0] e);
    exp_t x;
    x.name = name;
    x.sel  = sel;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic expect_lk(input string name, input logic h, input logic pt,
                           input logic [31:0] nxt);
    expect_v({name, "_hit"},  S_HIT,  {31'd0, h});
    expect_v({name, "_pt"},   S_PT,   {31'd0, pt});
    expect_v({name, "_next"}, S_NEXT, nxt);
  endtask

  task automatic check_all();
    exp_t        x;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      case (x.sel)
        S_HIT:   obs = {31'd0, hit_F};
        S_PT:    obs = {31'd0, pred_taken_F};
        S_NEXT:  obs = pred_next_F;
        S_MP:    obs = {31'd0, mispredict};
        S_STAT:  obs = {28'd0, stat_mispredict};
        default: obs = 32'hxxxx_xxxx;
      endcase
      checks++;
      assert (obs === x.exp) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", x.name, obs, x.exp);
      end
    end
  endtask

  task automatic drive_upd(input logic v, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic ptk,
                           input logic [31:0] pnx);
    upd_valid      = v;
    upd_pc         = pc;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_pred_taken = ptk;
    upd_pred_next  = pnx;
  endtask

  initial begin
    nRST       = 1'b0;
    pc_F       = 32'h0000_0040;
    invalidate = 1'b0;
    drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    // In reset
    #3;
    expect_lk("rst", 1'b0, 1'b0, 32'h0000_0044);
    expect_v("rst_stat", S_STAT, 32'd0);
    check_all();

    @(negedge CLK);
    nRST = 1'b1;

    // Allocate 0x40 -> 0x100; same-cycle lookup still misses
    drive_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    #2;
    expect_lk("alloc_same", 1'b0, 1'b0, 32'h0000_0044);
    expect_v("alloc_mp", S_MP, 32'd1);
    expect_v("alloc_stat0", S_STAT, 32'd0);
    check_all();
    @(negedge CLK);

    // Hit next cycle, weakly taken
    drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    expect_lk("after_alloc", 1'b1, 1'b1, 32'h0000_0100);
    expect_v("after_alloc_stat", S_STAT, 32'd1);
    expect_v("idle_mp", S_MP, 32'd0);
    check_all();
    @(negedge CLK);

    // Not-taken #1 (10 -> 01), predicted taken: direction mispredict
    drive_upd(1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    #2;
    expect_lk("nt1_same", 1'b1, 1'b1, 32'h0000_0100);
    expect_v("nt1_mp", S_MP, 32'd1);
    check_all();
    @(negedge CLK);

    // Not-taken #2 (01 -> 00), predicted not-taken; target field differs but ignored
    drive_upd(1'b1, 32'h40, 1'b0, 32'h999, 1'b0, 32'h44);
    #2;
    expect_lk("ctr01", 1'b1, 1'b0, 32'h0000_0044);
    expect_v("nt2_mp", S_MP, 32'd0);
    expect_v("nt1_stat", S_STAT, 32'd2);
    check_all();
    @(negedge CLK);

    // Not-taken #3 saturates at 00
    drive_upd(1'b1, 32'h40, 1'b0, 32'h100, 1'b0, 32'h44);
    #2;
    expect_lk("ctr00", 1'b1, 1'b0, 32'h0000_0044);
    expect_v("nt3_mp", S_MP, 32'd0);
    check_all();
    @(negedge CLK);

    // Taken (00 -> 01), predicted not-taken
    drive_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    #2;
    expect_lk("ctr00_sat", 1'b1, 1'b0, 32'h0000_0044);
    expect_v("tk_mp", S_MP, 32'd1);
    check_all();
    @(negedge CLK);

    // ctr 01 still not taken; taken with wrong target is a mispredict (01 -> 10)
    drive_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h104);
    #2;
    expect_lk("ctr01_again", 1'b1, 1'b0, 32'h0000_0044);
    expect_v("tgt_mp", S_MP, 32'd1);
    expect_v("stat3", S_STAT, 32'd3);
    check_all();
    @(negedge CLK);

    // Predicts taken again; alias 0x80 to same index, target 0x200
    drive_upd(1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
    #2;
    expect_lk("ctr10", 1'b1, 1'b1, 32'h0000_0100);
    expect_v("alias_mp", S_MP, 32'd1);
    expect_v("stat4", S_STAT, 32'd4);
    check_all();
    @(negedge CLK);

    // 0x40 evicted; upd_valid low with other inputs toggling
    drive_upd(1'b0, 32'h40, 1'b1, 32'h777, 1'b0, 32'h0);
    #2;
    expect_lk("alias_40", 1'b0, 1'b0, 32'h0000_0044);
    expect_v("noval_mp", S_MP, 32'd0);
    expect_v("stat5", S_STAT, 32'd5);
    check_all();
    pc_F = 32'h0000_0080;
    #1;
    expect_lk("alias_80", 1'b1, 1'b1, 32'h0000_0200);
    check_all();
    @(negedge CLK);

    // Toggling inputs did not change the table; now invalidate with an update
    pc_F       = 32'h0000_0080;
    invalidate = 1'b1;
    drive_upd(1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 32'h84);
    #2;
    expect_lk("noval_hold", 1'b1, 1'b1, 32'h0000_0200);
    expect_v("inv_mp", S_MP, 32'd1);
    expect_v("noval_stat", S_STAT, 32'd5);
    check_all();
    @(negedge CLK);

    // Everything misses; mispredict during invalidate was counted
    invalidate = 1'b0;
    drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    expect_lk("inv_80", 1'b0, 1'b0, 32'h0000_0084);
    expect_v("inv_stat", S_STAT, 32'd6);
    check_all();
    pc_F = 32'h0000_0040;
    #1;
    expect_lk("inv_40", 1'b0, 1'b0, 32'h0000_0044);
    check_all();
    pc_F = 32'hFFFF_FFFC;
    #1;
    expect_lk("wrap", 1'b0, 1'b0, 32'h0000_0000);
    check_all();
    @(negedge CLK);

    // 17 consecutive mispredicting updates saturate the 4-bit statistic
    pc_F = 32'h0000_0080;
    for (int i = 0; i < 17; i++) begin
      drive_upd(1'b1, 32'h1000, 1'b0, 32'h0, 1'b1, 32'h0);
      @(negedge CLK);
    end
    #2;
    expect_v("sat_stat", S_STAT, 32'd15);
    expect_v("sat_mp", S_MP, 32'd1);
    check_all();
    @(negedge CLK);
    #2;
    expect_v("sat_hold", S_STAT, 32'd15);
    expect_lk("sat_nt_miss", 1'b0, 1'b0, 32'h0000_0084);
    check_all();

    // Asynchronous reset between clock edges
    #1;
    nRST = 1'b0;
    #1;
    expect_v("async_rst_stat", S_STAT, 32'd0);
    check_all();
    @(negedge CLK);
    nRST = 1'b1;
    drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    expect_v("post_rst_stat", S_STAT, 32'd0);
    expect_lk("post_rst", 1'b0, 1'b0, 32'h0000_0084);
    check_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
